// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-path widths and the memory-access FSM state type,
// used by the destination mux, the register file and the memory access controller.
package cpu_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // The top address bit marks the region beyond the data RAM.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1];
  endfunction

endpackage

// File: rtl/wait_counter.sv
// 4-bit loadable down-counter with a zero flag; counts RAM wait states.
module wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count_r;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != 4'd0)) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 4'd0);

endmodule

// File: rtl/mem_dest_access.sv
// Multi-cycle data-memory access controller behind the destination-address mux.
// Optional MEM_FAULT_EN: requests with the top address bit set complete at once with a fault strobe.
module mem_dest_access
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_rd,
  input  logic              req_wr,
  output logic              stall,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              fault,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e state_r;
  state_e state_nxt_s;
  logic   op_we_r;
  logic   req_s;
  logic   fault_path_s;
  logic   cnt_zero_s;
  logic   start_s;
  logic   load_done_s;

  assign req_s = req_rd | req_wr;

`ifdef MEM_FAULT_EN
  assign fault_path_s = addr_out_of_range(req_addr);
`else
  assign fault_path_s = 1'b0;
`endif

  // A legal request leaving IDLE, and the WAIT cycle that completes a load.
  assign start_s     = (state_r == ST_IDLE) && req_s && !fault_path_s;
  assign load_done_s = (state_r == ST_WAIT) && cnt_zero_s && !op_we_r;

  wait_counter u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_r == ST_ACCESS),
    .dec      (state_r == ST_WAIT),
    .load_val (WAIT_LOAD),
    .zero     (cnt_zero_s)
  );

  // Next-state selection for the access sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_nxt_s = fault_path_s ? ST_DONE : ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_zero_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, request latches, RAM strobes and load result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      op_we_r   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      rd_data   <= {DATA_W{1'b0}};
      rd_valid  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      // Simultaneous read and write resolves to a store.
      mem_en   <= start_s;
      mem_we   <= start_s & req_wr;
      rd_valid <= load_done_s;
      if (start_s) begin
        op_we_r   <= req_wr;
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
      end
      if (load_done_s) begin
        rd_data <= mem_rdata;
      end
    end
  end

`ifdef MEM_FAULT_EN
  logic fault_r;

  // Fault strobe accompanies the DONE cycle of an out-of-range request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= (state_r == ST_IDLE) && req_s && fault_path_s;
    end
  end

  assign fault = fault_r;
`else
  assign fault = 1'b0;
`endif

  // DONE releases the core so it advances on that edge.
  assign stall = ((state_r == ST_IDLE) && req_s) ||
                 (state_r == ST_ACCESS) || (state_r == ST_WAIT);

endmodule

// File: tb/tb_mem_dest_access.sv
// Scoreboard bench for mem_dest_access: stimulus queues expected RAM operations and load
// results; a monitor pops and compares whenever mem_en, rd_valid or fault is presented.
module tb_mem_dest_access;

  localparam int TB_W   = 3;
  localparam int STALLS = 2 + TB_W;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [15:0] wdata;
  } memop_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_rd;
  logic        req_wr;
  logic        stall;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        fault;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        ram_init;
  logic [15:0] ram [0:255];

  memop_t      exp_mem[$];
  logic [15:0] exp_rd[$];
  int          exp_fault_n = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  mem_dest_access #(.ADDR_W(17), .DATA_W(16), .WAIT_CYCLES(TB_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .req_wr(req_wr), .stall(stall), .rd_data(rd_data),
    .rd_valid(rd_valid), .fault(fault), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] ram_idx(input logic [16:0] a);
    return {a[16], a[6:0]};
  endfunction

  // Synchronous RAM: data valid one cycle after enable, held until the next enable.
  always @(posedge clk) begin
    if (ram_init) begin
      ram[0]    <= 16'h0000;
      ram[1]    <= 16'h1111;
      ram[2]    <= 16'h2222;
      ram[3]    <= 16'h0000;
      ram[5]    <= 16'h0555;
      ram[10]   <= 16'hBEEF;
      ram[128]  <= 16'h5A5A;
      mem_rdata <= 16'h0000;
    end else if (mem_en) begin
      if (mem_we) ram[ram_idx(mem_addr)] <= mem_wdata;
      else        mem_rdata <= ram[ram_idx(mem_addr)];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic memop_t mk(input logic we, input logic [16:0] a, input logic [15:0] d);
    memop_t m;
    m.we = we; m.addr = a; m.wdata = d;
    return m;
  endfunction

  // Monitor: compares every presented RAM strobe, load completion and fault against the queues.
  always @(negedge clk) begin
    memop_t e;
    logic [15:0] r;
    if (mem_en) begin
      if (exp_mem.size() == 0) check("mem_en_unexpected", 32'(mem_en), 32'd0);
      else begin
        e = exp_mem.pop_front();
        check("mem_we", 32'(mem_we), 32'(e.we));
        check("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
      end
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      else begin
        r = exp_rd.pop_front();
        check("rd_data", 32'(rd_data), 32'(r));
      end
    end
    if (fault) begin
      if (exp_fault_n == 0) check("fault_unexpected", 32'(fault), 32'd0);
      else exp_fault_n--;
    end
  end

  // Issues one request, counts stalled cycles, samples mem_en one cycle later; returns in DONE.
  task automatic access(input logic rd, input logic wr, input logic [16:0] a, input logic [15:0] d,
                        input int exp_stall, input logic exp_en1, input logic hold, input string tag);
    int   n;
    logic en1;
    @(negedge clk);
    req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d;
    #1;
    n = 0; en1 = 1'b0;
    while (stall && n < 40) begin
      n++;
      @(negedge clk); #1;
      if (n == 1) en1 = mem_en;
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    check({tag, "_mem_en_next"}, 32'(en1), 32'(exp_en1));
    if (!hold) begin
      req_rd = 1'b0; req_wr = 1'b0;
    end
  endtask

  task automatic load(input logic [16:0] a, input logic [15:0] exp_d, input logic hold, input string tag);
    exp_mem.push_back(mk(1'b0, a, 16'h0000));
    exp_rd.push_back(exp_d);
    access(1'b1, 1'b0, a, 16'h0000, STALLS, 1'b1, hold, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ram_init = 1'b1;
    req_rd = 1'b0; req_wr = 1'b0; req_addr = 17'h0; req_wdata = 16'h0;
    repeat (3) @(negedge clk);
    ram_init = 1'b0;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    load(17'd10, 16'hBEEF, 1'b0, "ld10");
    check("ld10_done_rd_valid", 32'(rd_valid), 32'd1);
    check("ld10_done_rd_data", 32'(rd_data), 32'h0000BEEF);

    exp_mem.push_back(mk(1'b1, 17'd0, 16'h1234));
    access(1'b0, 1'b1, 17'd0, 16'h1234, STALLS, 1'b1, 1'b0, "st0");
    check("st0_done_rd_valid", 32'(rd_valid), 32'd0);
    check("st0_rd_data_kept", 32'(rd_data), 32'h0000BEEF);
    load(17'd0, 16'h1234, 1'b0, "ld0");

    exp_mem.push_back(mk(1'b1, 17'd3, 16'h00AA));
    access(1'b1, 1'b1, 17'd3, 16'h00AA, STALLS, 1'b1, 1'b0, "rdwr3");
    check("rdwr3_done_rd_valid", 32'(rd_valid), 32'd0);
    check("rdwr3_rd_data_kept", 32'(rd_data), 32'h00001234);
    load(17'd3, 16'h00AA, 1'b0, "ld3");

    load(17'd1, 16'h1111, 1'b1, "b2b1");
    load(17'd2, 16'h2222, 1'b0, "b2b2");

`ifdef MEM_FAULT_EN
    exp_fault_n++;
    access(1'b1, 1'b0, 17'h10000, 16'h0000, 1, 1'b0, 1'b0, "flt");
    check("flt_fault", 32'(fault), 32'd1);
    check("flt_rd_valid", 32'(rd_valid), 32'd0);
    check("flt_rd_data_kept", 32'(rd_data), 32'h00002222);
`else
    load(17'h10000, 16'h5A5A, 1'b0, "hi");
`endif

    exp_mem.push_back(mk(1'b0, 17'd5, 16'h0000));
    @(negedge clk);
    req_rd = 1'b1; req_addr = 17'd5;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; req_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("wrst_stall", 32'(stall), 32'd0);
    check("wrst_rd_data", 32'(rd_data), 32'd0);
    check("wrst_mem_en", 32'(mem_en), 32'd0);
    check("wrst_rd_valid", 32'(rd_valid), 32'd0);
    load(17'd10, 16'hBEEF, 1'b0, "post_rst");

    repeat (TB_W + 4) @(negedge clk);
    check("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("fault_pending", 32'(exp_fault_n), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
